// File: rtl/tank_level_encoder.sv
// Tank probe encoder: synchronizes and debounces a 7-column probe pattern, then encodes it as an emptied level.
// Optional build macro FAULT_LATCH_EN makes sensor_fault sticky until reset.
module tank_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] column_level,
  output logic [2:0] water_level,
  output logic       level_valid,
  output logic       level_changed,
  output logic       sensor_fault
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] ALL_WET = 7'b1111111;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic [2:0] wl_q, wl_d;
  logic       vld_q, vld_d;
  logic       chg_q, chg_d;
  logic       flt_q, flt_d;

  logic       match;
  logic       accept;
  logic       legal;
  logic [2:0] enc;

  // A legal code is all ones shifted left, i.e. dry columns contiguous from bit 0.
  function automatic logic is_legal(input logic [6:0] code);
    logic       ok;
    logic [6:0] pat;
    ok  = 1'b0;
    pat = ALL_WET;
    for (int n = 0; n < 8; n++) begin
      if (code == pat) ok = 1'b1;
      pat = {pat[5:0], 1'b0};
    end
    return ok;
  endfunction

  function automatic logic [2:0] count_zeros(input logic [6:0] code);
    logic [2:0] z;
    z = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!code[i]) z = z + 3'd1;
    end
    return z;
  endfunction

  assign sync1_d = column_level;
  assign sync2_d = sync1_q;
  assign match   = (sync2_q == cand_q);
  assign accept  = match && (cnt_q == CNT_MAX);
  assign legal   = is_legal(sync2_q);
  assign enc     = count_zeros(sync2_q);

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (!match) begin
      cand_d = sync2_q;
      cnt_d  = 4'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    vld_d   = vld_q;
    chg_d   = 1'b0;
    flt_d   = flt_q;
    if (accept) begin
      if (legal) begin
        state_d = TRACK;
        wl_d    = enc;
        vld_d   = 1'b1;
        chg_d   = (state_q != TRACK) || (enc != wl_q);
`ifdef FAULT_LATCH_EN
        flt_d   = flt_q;
`else
        flt_d   = 1'b0;
`endif
      end else begin
        // Level is held so the last good reading survives a faulty probe.
        state_d = FAULT;
        vld_d   = 1'b0;
        flt_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= ALL_WET;
      sync2_q <= ALL_WET;
      cand_q  <= ALL_WET;
      cnt_q   <= 4'd0;
      state_q <= INIT;
      wl_q    <= 3'd0;
      vld_q   <= 1'b0;
      chg_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wl_q    <= wl_d;
      vld_q   <= vld_d;
      chg_q   <= chg_d;
      flt_q   <= flt_d;
    end
  end

  assign water_level   = wl_q;
  assign level_valid   = vld_q;
  assign level_changed = chg_q;
  assign sensor_fault  = flt_q;

endmodule

// File: doc/tank_level_encoder.md
TANK_LEVEL_ENCODER -- requirements
Module: tank_level_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive identical synchronized samples (legal range 1..15) required before a probe pattern is accepted.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port column_level, input, 7 bits: asynchronous tank probe pattern, one bit per column, 1 = water present.
REQ-005 Port water_level, output, 3 bits: encoded emptied level, 0 = full (7'b1111111), 7 = empty (7'b0000000).
REQ-006 Port level_valid, output, 1 bit: high while water_level reflects an accepted, legal probe pattern.
REQ-007 Port level_changed, output, 1 bit: single-cycle pulse when water_level takes a new accepted value.
REQ-008 Port sensor_fault, output, 1 bit: high when an accepted pattern is not a legal thermometer code.

Function
REQ-009 column_level SHALL pass through a 2-flop synchronizer; only the second-stage value (sample) is used downstream.
REQ-010 Debounce: sample != candidate -> candidate <= sample, count <= 0; sample == candidate -> count increments, saturating at DEBOUNCE_CYCLES-1.
REQ-011 Accept strobe SHALL be asserted in any cycle where sample == candidate and count == DEBOUNCE_CYCLES-1, and SHALL remain asserted each cycle while this condition holds.
REQ-012 Legal codes, exactly eight: 1111111->0, 1111110->1, 1111100->2, 1111000->3, 1110000->4, 1100000->5, 1000000->6, 0000000->7, i.e. water_level = number of zero bits, with zeros contiguous from bit 0.
REQ-013 FSM states: INIT (after reset, nothing accepted), TRACK (last accepted code legal), FAULT (last accepted code illegal).
REQ-014 INIT/TRACK/FAULT on accept of legal code -> TRACK: water_level <= encoded value, level_valid <= 1.
REQ-015 level_changed SHALL pulse for exactly one cycle, coincident with the register update, when the accepted legal value differs from water_level or level_valid was 0; no pulse on re-acceptance of an unchanged value.
REQ-016 Any state on accept of illegal code -> FAULT: water_level holds its previous value, level_valid <= 0, sensor_fault <= 1, no level_changed pulse.
REQ-017 Outputs are registered; a column_level step held constant appears on water_level DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it.
REQ-018 A pattern change before acceptance restarts debounce; outputs SHALL NOT change during bounce.
REQ-019 Without accept, the FSM and all outputs hold.

Reset
REQ-020 reset high at a rising edge: water_level <= 3'b000, level_valid <= 0, level_changed <= 0, sensor_fault <= 0, FSM <= INIT, count <= 0, candidate and synchronizer flops <= 7'b1111111.
REQ-021 reset SHALL override all other activity in the same cycle, including a coincident accept; debounce restarts from zero after release.

Configuration
REQ-022 Macro FAULT_LATCH_EN defined: sensor_fault is sticky once set and clears only on reset; FAULT -> TRACK still restores level_valid and water_level.
REQ-023 Macro FAULT_LATCH_EN undefined: sensor_fault clears on the same edge the FSM enters TRACK.

Verification (DEBOUNCE_CYCLES = 4)
REQ-024 Reset, then hold 7'b1111000 -> water_level = 3, level_valid = 1, one level_changed pulse, all exactly 7 edges after the first sampling edge.
REQ-025 Toggle 1111100/1111000 every 2 cycles for 20 cycles, then hold 1111100 -> no output change during toggling; water_level = 2 seven edges after the final change.
REQ-026 From level 3, hold illegal 7'b1011000 -> sensor_fault = 1, level_valid = 0, water_level stays 3, no level_changed pulse.
REQ-027 Then hold 7'b0000000 -> water_level = 7, level_valid = 1, one level_changed pulse; sensor_fault = 1 with FAULT_LATCH_EN, 0 without.
REQ-028 Hold 7'b1111111 for 50 cycles -> exactly one level_changed pulse; assert reset mid-stream -> all outputs at reset values on the next edge, FSM = INIT.
